// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side definitions: widths, reset PC, bubble word,
// fetch FSM states and the IF/ID bundle.
package fetch_stage_pkg;
   localparam int          XLEN      = 32;
   localparam int          ADDR_W    = 10;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] instr;
      logic            valid;
   } if_id_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load captures, flush injects a bubble,
// neither holds (stall).
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_INSTR
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);
   always_ff @(posedge clk) begin
      if (rst) begin
         q.pc    <= '0;
         q.pc4   <= 32'd4;
         q.instr <= NOP;
         q.valid <= 1'b0;
      end else if (flush) begin
         q.instr <= NOP;
         q.valid <= 1'b0;
      end else if (load) begin
         q <= d;
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC select, fetch FSM and fault
// detection in front of a combinational instruction ROM.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int          ADDR_W    = fetch_stage_pkg::ADDR_W,
   parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [31:0]       rom_data_i,
   output logic [31:0]       if_pc_o,
   output logic [31:0]       if_pc4_o,
   output logic [31:0]       if_instr_o,
   output logic              if_valid_o,
   output logic              fault_o
);
   fetch_state_t state, state_n;
   logic [31:0]  pc, pc_n, pc_inc;
   logic         load, flush;
   logic         pc_bad, tgt_bad;
   if_id_t       d, q;

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
   endfunction

   assign pc_inc  = pc + 32'd4;
   assign pc_bad  = bad_addr(pc);
   assign tgt_bad = bad_addr(redirect_pc_i);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= BOOT;
         pc    <= RESET_PC;
      end else begin
         state <= state_n;
         pc    <= pc_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      load    = 1'b0;
      flush   = 1'b0;
      unique case (state)
         BOOT: begin
            state_n = RUN;
            if (redirect_i) begin
               if (tgt_bad) state_n = FAULT;
               else         pc_n    = redirect_pc_i;
            end
         end
         RUN: begin
            if (redirect_i) begin
               flush = 1'b1;
               if (tgt_bad) state_n = FAULT;
               else         pc_n    = redirect_pc_i;
            end else if (pc_bad) begin
               // catches sequential run-off past the last ROM word
               flush   = 1'b1;
               state_n = FAULT;
            end else if (!stall_i) begin
               load = 1'b1;
               pc_n = pc_inc;
            end
         end
         FAULT: flush = 1'b1;
         default: begin
            flush   = 1'b1;
            state_n = FAULT;
         end
      endcase
   end

   assign d.pc    = pc;
   assign d.pc4   = pc_inc;
   assign d.instr = rom_data_i;
   assign d.valid = 1'b1;

   if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
      .clk   (CLK),
      .rst   (RST),
      .load  (load),
      .flush (flush),
      .d     (d),
      .q     (q)
   );

   assign rom_addr_o = pc[ADDR_W+1:2];
   assign if_pc_o    = q.pc;
   assign if_pc4_o   = q.pc4;
   assign if_instr_o = q.instr;
   assign if_valid_o = q.valid;
   assign fault_o    = (state == FAULT);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-bench ROM image.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic [9:0]  rom_addr_o;
   logic [31:0] rom_data_i;
   logic [31:0] if_pc_o, if_pc4_o, if_instr_o;
   logic        if_valid_o, fault_o;

   logic [31:0] mem [1024];
   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   assign rom_data_i = mem[rom_addr_o];

   fetch_stage dut (
      .CLK           (CLK),
      .RST           (RST),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .rom_addr_o    (rom_addr_o),
      .rom_data_i    (rom_data_i),
      .if_pc_o       (if_pc_o),
      .if_pc4_o      (if_pc4_o),
      .if_instr_o    (if_instr_o),
      .if_valid_o    (if_valid_o),
      .fault_o       (fault_o)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic redir(input logic [31:0] a);
      redirect_i    = 1'b1;
      redirect_pc_i = a;
      step();
      redirect_i    = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 1024; k++)
         mem[k] = 32'hF1B0_0000 ^ (k * 32'h0001_0003) ^ 32'h33;

      // reset
      step();
      step();
      chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
      chk("rst_pc", if_pc_o, 32'd0);
      chk("rst_pc4", if_pc4_o, 32'd4);
      chk("rst_instr", if_instr_o, NOP);
      chk("rst_fault", {31'd0, fault_o}, 32'd0);
      chk("rst_addr", {22'd0, rom_addr_o}, 32'd0);

      // free run
      RST = 1'b0;
      step();
      chk("boot_valid", {31'd0, if_valid_o}, 32'd0);
      for (int k = 0; k < 28; k++) begin
         step();
         chk("run_valid", {31'd0, if_valid_o}, 32'd1);
         chk("run_pc", if_pc_o, 32'(4 * k));
         chk("run_pc4", if_pc4_o, 32'(4 * k + 4));
         chk("run_instr", if_instr_o, mem[k]);
      end

      // restart from 0 and stall at if_pc=0x10
      redir(32'h0);
      chk("r0_bubble", {31'd0, if_valid_o}, 32'd0);
      chk("r0_nop", if_instr_o, NOP);
      for (int k = 0; k < 5; k++) step();
      chk("pre_stall_pc", if_pc_o, 32'h10);
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_pc", if_pc_o, 32'h10);
         chk("stall_instr", if_instr_o, mem[4]);
         chk("stall_addr", {22'd0, rom_addr_o}, 32'd5);
         chk("stall_valid", {31'd0, if_valid_o}, 32'd1);
      end
      stall_i = 1'b0;
      step();
      chk("unstall_pc", if_pc_o, 32'h14);
      chk("unstall_instr", if_instr_o, mem[5]);

      // redirect together with stall
      stall_i = 1'b1;
      redir(32'h40);
      stall_i = 1'b0;
      chk("rs_valid", {31'd0, if_valid_o}, 32'd0);
      chk("rs_nop", if_instr_o, NOP);
      step();
      chk("rs_pc", if_pc_o, 32'h40);
      chk("rs_instr", if_instr_o, mem[16]);
      chk("rs_valid2", {31'd0, if_valid_o}, 32'd1);

      // reset mid-stream while stalled at pc=0x24
      redir(32'h24);
      stall_i = 1'b1;
      step();
      chk("pre_rst_addr", {22'd0, rom_addr_o}, 32'd9);
      RST = 1'b1;
      step();
      chk("mrst_addr", {22'd0, rom_addr_o}, 32'd0);
      chk("mrst_valid", {31'd0, if_valid_o}, 32'd0);
      chk("mrst_fault", {31'd0, fault_o}, 32'd0);
      RST = 1'b0;
      stall_i = 1'b0;
      step();
      step();
      chk("mrst_pc0", if_pc_o, 32'h0);
      chk("mrst_i0", if_instr_o, mem[0]);
      step();
      chk("mrst_i1", if_instr_o, mem[1]);

      // misaligned redirect
      redir(32'h42);
      chk("mis_fault", {31'd0, fault_o}, 32'd1);
      chk("mis_valid", {31'd0, if_valid_o}, 32'd0);
      chk("mis_nop", if_instr_o, NOP);
      redir(32'h0);
      step();
      chk("mis_sticky", {31'd0, fault_o}, 32'd1);
      chk("mis_valid2", {31'd0, if_valid_o}, 32'd0);
      RST = 1'b1;
      step();
      chk("mis_clr", {31'd0, fault_o}, 32'd0);
      chk("mis_addr", {22'd0, rom_addr_o}, 32'd0);

      // redirect during BOOT to last word, then run off the end
      RST = 1'b0;
      redir(32'h0FFC);
      chk("end_boot_valid", {31'd0, if_valid_o}, 32'd0);
      step();
      chk("end_pc", if_pc_o, 32'h0FFC);
      chk("end_instr", if_instr_o, mem[1023]);
      chk("end_fault0", {31'd0, fault_o}, 32'd0);
      step();
      chk("wrap_fault", {31'd0, fault_o}, 32'd1);
      chk("wrap_valid", {31'd0, if_valid_o}, 32'd0);
      chk("wrap_nop", if_instr_o, NOP);
      step();
      chk("wrap_pc", if_pc_o, 32'h0FFC);

      // out-of-range redirect from RUN
      RST = 1'b1;
      step();
      RST = 1'b0;
      step();
      redir(32'h0000_2000);
      chk("oor_fault", {31'd0, fault_o}, 32'd1);
      chk("oor_valid", {31'd0, if_valid_o}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
